// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } lsu_err_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 > F3_W);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return (off != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane steering / byte enables and load extract with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_byte_off, 3'b000};

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = w_shifted;
        case (i_funct3)
            F3_B: begin
                o_wstrb = 4'b0001 << i_byte_off;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            F3_H: begin
                o_wstrb = 4'b0011 << i_byte_off;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            F3_BU: o_rdata = {24'd0, w_shifted[7:0]};
            F3_HU: o_rdata = {16'd0, w_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: request FSM, request latches, bus timeout and registered results.
//  state    | meaning
//  IDLE     | ready for a new access
//  REQ      | mem_valid held until mem_ready
//  WAIT_RSP | load issued, waiting for mem_rvalid
//  DONE     | one-cycle completion pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t  r_state, w_state_nxt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [1:0]  r_err, w_err_nxt;
    logic [7:0]  r_cnt;
    logic        w_accept, w_timeout, w_capture;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata_lanes, w_rdata_ext;

    lsu_align u_align (
        .i_funct3   (r_funct3),
        .i_byte_off (r_addr[1:0]),
        .i_wdata    (r_wdata),
        .i_rdata    (mem_rdata),
        .o_wstrb    (w_strb),
        .o_wdata    (w_wdata_lanes),
        .o_rdata    (w_rdata_ext)
    );

    assign w_accept  = lsu_valid && (r_state == S_IDLE);
    // >= rather than == so a load handshaking exactly at the limit still times out in WAIT_RSP
    assign w_timeout = (r_cnt >= CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (lsu_valid) begin
                    w_err_nxt = ERR_OK;
                    if (is_illegal(lsu_we, lsu_funct3)) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = ERR_ILLEGAL;
                    end else if (is_misaligned(lsu_funct3, lsu_addr[1:0])) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = ERR_MISALIGN;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    w_state_nxt = r_we ? S_DONE : S_WAIT_RSP;
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = ERR_TIMEOUT;
                end
            end
            S_WAIT_RSP: begin
                if (mem_rvalid) begin
                    w_state_nxt = S_DONE;
                    w_capture   = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = ERR_TIMEOUT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= ERR_OK;
            r_cnt    <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_we     <= lsu_we;
                r_funct3 <= lsu_funct3;
                r_addr   <= lsu_addr;
                r_wdata  <= lsu_wdata;
                r_rdata  <= 32'd0;
                r_cnt    <= 8'd0;
            end else if (r_state == S_REQ || r_state == S_WAIT_RSP) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_capture)
                r_rdata <= w_rdata_ext;
        end
    end

    assign lsu_ready = (r_state == S_IDLE);
    assign lsu_done  = (r_state == S_DONE);
    assign lsu_rdata = r_rdata;
    assign lsu_err   = r_err;
    assign mem_valid = (r_state == S_REQ);
    assign mem_we    = r_we;
    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wstrb = r_we ? w_strb : 4'b0000;
    assign mem_wdata = w_wdata_lanes;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized accesses against a
// behavioural model, and an asynchronous-reset abort sequence.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, lsu_ready, lsu_we, lsu_done;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [1:0]  lsu_err;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_we     (lsu_we),
        .lsu_funct3 (lsu_funct3),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_done   (lsu_done),
        .lsu_rdata  (lsu_rdata),
        .lsu_err    (lsu_err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          rdy;
        int          rv;
        logic [31:0] rdata;
        logic [1:0]  err;
        int          done;
        logic [31:0] rd;
        logic [3:0]  strb;
        logic [31:0] wd;
        int          nv;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle counts are relative to the accepting edge (cycle 0). rdy = extra cycles
    // mem_valid waits before mem_ready; rv = cycles after the handshake before mem_rvalid.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, input int rdy, input int rv,
                                  output logic [1:0] e, output int dc, output logic [31:0] rd,
                                  output logic [3:0] st, output logic [31:0] wd, output int nv);
        int          off, cyc;
        logic [31:0] sh;
        logic        illegal, mis;
        off     = int'(addr[1:0]);
        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
        mis     = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
        e  = 2'd0;
        dc = 1;
        rd = 32'd0;
        nv = 0;
        st = 4'd0;
        wd = wdata;
        if (we) begin
            case (f3[1:0])
                2'd0:    begin st = 4'b0001 << off; wd = {4{wdata[7:0]}};  end
                2'd1:    begin st = 4'b0011 << off; wd = {2{wdata[15:0]}}; end
                default: st = 4'b1111;
            endcase
        end
        if (illegal) begin
            e = 2'd3;
        end else if (mis) begin
            e = 2'd1;
        end else begin
            cyc = we ? rdy + 1 : rdy + rv + 2;
            if (cyc > TO) begin
                e  = 2'd2;
                dc = TO + 1;
                nv = (rdy + 1 < TO) ? rdy + 1 : TO;
            end else begin
                dc = cyc + 1;
                nv = rdy + 1;
                if (!we) begin
                    sh = rdata >> (8 * off);
                    case (f3)
                        3'd0:    rd = int'($signed(sh[7:0]));
                        3'd1:    rd = int'($signed(sh[15:0]));
                        3'd4:    rd = {24'd0, sh[7:0]};
                        3'd5:    rd = {16'd0, sh[15:0]};
                        default: rd = rdata;
                    endcase
                end
            end
        end
    endfunction

    task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int rdy, input int rv, input logic [31:0] rdata,
                              input logic [1:0] e_err, input int e_done, input logic [31:0] e_rd,
                              input logic [3:0] e_strb, input logic [31:0] e_wd, input int e_nv);
        int          hs, vc, dc;
        logic [3:0]  st;
        logic [31:0] wd, ma;
        hs = -1; vc = 0; dc = -1; st = 4'd0; wd = 32'd0; ma = 32'd0;
        @(negedge clk);
        check({tag, " ready_idle"}, 32'(lsu_ready), 32'd1);
        lsu_valid  = 1'b1;
        lsu_we     = we;
        lsu_funct3 = f3;
        lsu_addr   = addr;
        lsu_wdata  = wdata;
        mem_rdata  = rdata;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 20 && dc < 0; c++) begin
            @(negedge clk);
            lsu_valid  = 1'b0;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (lsu_done) begin
                dc = c;
                check({tag, " rdata"}, lsu_rdata, e_rd);
                check({tag, " err"}, 32'(lsu_err), 32'(e_err));
                check({tag, " ready_in_done"}, 32'(lsu_ready), 32'd0);
            end else begin
                if (mem_valid) begin
                    vc++;
                    st = mem_wstrb;
                    wd = mem_wdata;
                    ma = mem_addr;
                    if (vc > rdy) begin
                        mem_ready = 1'b1;
                        hs = c;
                    end
                end
                if (hs >= 0 && !we && c >= hs + 1 + rv)
                    mem_rvalid = 1'b1;
            end
        end
        check({tag, " done_cycle"}, 32'(dc), 32'(e_done));
        check({tag, " valid_cycles"}, 32'(vc), 32'(e_nv));
        if (e_nv > 0) begin
            check({tag, " strb"}, 32'(st), 32'(e_strb));
            check({tag, " mem_addr"}, ma, addr & 32'hFFFF_FFFC);
            if (we)
                check({tag, " mem_wdata"}, wd, e_wd);
        end
        @(negedge clk);
        check({tag, " ready_after"}, 32'({lsu_ready, lsu_done}), 32'b10);
    endtask

    initial begin
        logic [1:0]  e;
        int          dc, nv, rdy, rv;
        logic [31:0] rd, wd, a, w, r;
        logic [3:0]  st;
        logic        we, seen;
        logic [2:0]  f3;

        rst = 1'b1;
        lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0; lsu_addr = 32'd0; lsu_wdata = 32'd0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ready", 32'(lsu_ready), 32'd1);
        check("reset done_err", 32'({lsu_done, lsu_err}), 32'd0);
        check("reset rdata", lsu_rdata, 32'd0);
        check("reset mem_ctl", 32'({mem_valid, mem_we, mem_wstrb}), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        //                we    f3    addr          wdata         rdy rv rdata         err  done rd            strb     wd            nv
        tbl.push_back('{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,        2'd0, 2, 32'h0,        4'b1111, 32'hDEADBEEF, 1});
        tbl.push_back('{1'b1, 3'd0, 32'h103, 32'h000000A5, 0, 0, 32'h0,        2'd0, 2, 32'h0,        4'b1000, 32'hA5A5A5A5, 1});
        tbl.push_back('{1'b0, 3'd0, 32'h102, 32'h0,        0, 0, 32'h1280FF00, 2'd0, 3, 32'hFFFFFF80, 4'b0000, 32'h0,        1});
        tbl.push_back('{1'b0, 3'd4, 32'h102, 32'h0,        0, 0, 32'h1280FF00, 2'd0, 3, 32'h00000080, 4'b0000, 32'h0,        1});
        tbl.push_back('{1'b0, 3'd1, 32'h102, 32'h0,        0, 0, 32'h1280FF00, 2'd0, 3, 32'h00001280, 4'b0000, 32'h0,        1});
        tbl.push_back('{1'b0, 3'd2, 32'h101, 32'h0,        0, 0, 32'h0,        2'd1, 1, 32'h0,        4'b0000, 32'h0,        0});
        tbl.push_back('{1'b0, 3'd3, 32'h100, 32'h0,        0, 0, 32'h0,        2'd3, 1, 32'h0,        4'b0000, 32'h0,        0});
        tbl.push_back('{1'b0, 3'd7, 32'h103, 32'h0,        0, 0, 32'h0,        2'd3, 1, 32'h0,        4'b0000, 32'h0,        0});
        tbl.push_back('{1'b1, 3'd1, 32'h102, 32'h1234ABCD, 0, 0, 32'h0,        2'd0, 2, 32'h0,        4'b1100, 32'hABCDABCD, 1});
        tbl.push_back('{1'b1, 3'd4, 32'h100, 32'h11111111, 0, 0, 32'h0,        2'd3, 1, 32'h0,        4'b0000, 32'h0,        0});
        tbl.push_back('{1'b1, 3'd2, 32'h200, 32'hCAFEF00D, 3, 0, 32'h0,        2'd0, 5, 32'h0,        4'b1111, 32'hCAFEF00D, 4});
        tbl.push_back('{1'b1, 3'd2, 32'h204, 32'h01020304, 99, 0, 32'h0,       2'd2, 5, 32'h0,        4'b1111, 32'h01020304, 4});
        tbl.push_back('{1'b0, 3'd1, 32'h100, 32'h0,        1, 1, 32'h00008001, 2'd0, 5, 32'hFFFF8001, 4'b0000, 32'h0,        2});
        tbl.push_back('{1'b0, 3'd2, 32'h300, 32'h0,        0, 3, 32'h55555555, 2'd2, 5, 32'h0,        4'b0000, 32'h0,        1});
        tbl.push_back('{1'b1, 3'd1, 32'h101, 32'h0000BEEF, 0, 0, 32'h0,        2'd1, 1, 32'h0,        4'b0000, 32'h0,        0});

        foreach (tbl[i])
            run_access($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                       tbl[i].rdy, tbl[i].rv, tbl[i].rdata, tbl[i].err, tbl[i].done,
                       tbl[i].rd, tbl[i].strb, tbl[i].wd, tbl[i].nv);

        for (int n = 0; n < 80; n++) begin
            we  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            w   = $urandom;
            r   = $urandom;
            rdy = $urandom_range(0, 5);
            rv  = $urandom_range(0, 3);
            if (!we && rdy == TO - 1)
                rdy = $urandom_range(0, TO - 2);
            model(we, f3, a, w, r, rdy, rv, e, dc, rd, st, wd, nv);
            run_access($sformatf("rnd%0d", n), we, f3, a, w, rdy, rv, r, e, dc, rd, st, wd, nv);
        end

        // reset while a load waits for its response
        @(negedge clk);
        lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'd2; lsu_addr = 32'h400;
        @(posedge clk);
        @(negedge clk);
        lsu_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("rst_pre wait_state", 32'({lsu_ready, mem_valid, lsu_done}), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_abort mem_valid", 32'(mem_valid), 32'd0);
        check("rst_abort ready", 32'(lsu_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            seen |= lsu_done;
        end
        check("rst_late_rvalid done", 32'(seen), 32'd0);
        check("rst_late_rvalid rdata", lsu_rdata, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
